// File: rtl/in_service_control.sv
// 8259A in-service control: 8086 two-pulse INTA sequencing, ISR, EOI/rotation, vector byte drive.
// All outputs registered (1-cycle latency from the qualifying sample); no backpressure, INTA edges pace the sequence.
module in_service_control #(
  parameter logic [4:0] VECTOR_RESET = 5'b00000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       interrupt_ack_n,
  input  logic [4:0] vector_base,
  input  logic       vector_base_load,
  input  logic       auto_eoi,
  input  logic       rotate_on_aeoi,
  input  logic       eoi_nonspecific,
  input  logic       eoi_specific,
  input  logic       set_priority,
  input  logic       rotate_on_eoi,
  input  logic [2:0] ocw2_level,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state, state_nxt;
  logic       ack_prev, ack_fall, ack_rise;
  logic [2:0] level, level_nxt;
  logic       spurious, spurious_nxt;
  logic [4:0] base, base_nxt;
  logic [2:0] req_level;
  logic       req_any;
  logic       ns_found;
  logic [2:0] ns_level, ns_idx;
  logic [7:0] isr_nxt, clr_nxt, dout_nxt;
  logic [2:0] rot_nxt;
  logic       int_nxt, den_nxt, cmd_rot;

  assign ack_fall = !interrupt_ack_n && ack_prev;
  assign ack_rise = interrupt_ack_n && !ack_prev;
  assign req_any  = |interrupt;

  // Lowest set index wins if the resolver ever presents more than one bit.
  always_comb begin
    req_level = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (interrupt[i]) req_level = 3'(i);
  end

  // Non-specific EOI target: first set ISR bit above the lowest-priority level, wrapping.
  always_comb begin
    ns_found = 1'b0;
    ns_level = 3'd0;
    ns_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      ns_idx = priority_rotate + 3'(k);
      if (!ns_found && in_service_register[ns_idx]) begin
        ns_found = 1'b1;
        ns_level = ns_idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ack_fall) state_nxt = ACK1;
      ACK1:    if (ack_rise) state_nxt = WAIT2;
      WAIT2:   if (ack_fall) state_nxt = ACK2;
      ACK2:    if (ack_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    isr_nxt      = in_service_register;
    rot_nxt      = priority_rotate;
    cmd_rot      = 1'b0;
    clr_nxt      = 8'h00;
    level_nxt    = level;
    spurious_nxt = spurious;
    dout_nxt     = data_out;
    den_nxt      = data_out_enable;
    base_nxt     = vector_base_load ? vector_base : base;
    int_nxt      = (state == IDLE) && !ack_fall && req_any;

    // OCW2 commands act on the pre-update ISR; the INTA set below overrides on the same bit.
    if (eoi_specific) begin
      isr_nxt[ocw2_level] = 1'b0;
      if (rotate_on_eoi) begin
        rot_nxt = ocw2_level;
        cmd_rot = 1'b1;
      end
    end else if (eoi_nonspecific) begin
      if (ns_found) begin
        isr_nxt[ns_level] = 1'b0;
        if (rotate_on_eoi) begin
          rot_nxt = ns_level;
          cmd_rot = 1'b1;
        end
      end
    end else if (set_priority) begin
      rot_nxt = ocw2_level;
      cmd_rot = 1'b1;
    end

    case (state)
      IDLE: if (ack_fall) begin
        if (req_any) begin
          level_nxt          = req_level;
          spurious_nxt       = 1'b0;
          isr_nxt[req_level] = 1'b1;
          clr_nxt            = 8'b1 << req_level;
        end else begin
          level_nxt    = 3'd7;
          spurious_nxt = 1'b1;
        end
      end
      WAIT2: if (ack_fall) begin
        dout_nxt = {base, level};
        den_nxt  = 1'b1;
      end
      ACK2: if (ack_rise) begin
        den_nxt = 1'b0;
        if (auto_eoi && !spurious) begin
          isr_nxt[level] = 1'b0;
          if (rotate_on_aeoi && !cmd_rot) rot_nxt = level;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_prev                <= 1'b1;
      level                   <= 3'd0;
      spurious                <= 1'b0;
      base                    <= VECTOR_RESET;
      int_out                 <= 1'b0;
      in_service_register     <= 8'h00;
      priority_rotate         <= 3'b111;
      clear_interrupt_request <= 8'h00;
      data_out                <= 8'h00;
      data_out_enable         <= 1'b0;
    end else begin
      ack_prev                <= interrupt_ack_n;
      level                   <= level_nxt;
      spurious                <= spurious_nxt;
      base                    <= base_nxt;
      int_out                 <= int_nxt;
      in_service_register     <= isr_nxt;
      priority_rotate         <= rot_nxt;
      clear_interrupt_request <= clr_nxt;
      data_out                <= dout_nxt;
      data_out_enable         <= den_nxt;
    end
  end

endmodule

// File: tb/tb_in_service_control.sv
// Directed bench for in_service_control: protocol-level reference model checked every cycle plus literal spot checks.
module tb_in_service_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] interrupt = 8'h00;
  logic       interrupt_ack_n = 1'b1;
  logic [4:0] vector_base = 5'b00000;
  logic       vector_base_load = 1'b0;
  logic       auto_eoi = 1'b0;
  logic       rotate_on_aeoi = 1'b0;
  logic       eoi_nonspecific = 1'b0;
  logic       eoi_specific = 1'b0;
  logic       set_priority = 1'b0;
  logic       rotate_on_eoi = 1'b0;
  logic [2:0] ocw2_level = 3'd0;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] clear_interrupt_request;
  logic [7:0] data_out;
  logic       data_out_enable;

  int checks = 0;
  int errors = 0;

  in_service_control #(.VECTOR_RESET(5'b00000)) dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .interrupt_ack_n(interrupt_ack_n),
    .vector_base(vector_base), .vector_base_load(vector_base_load), .auto_eoi(auto_eoi),
    .rotate_on_aeoi(rotate_on_aeoi), .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific),
    .set_priority(set_priority), .rotate_on_eoi(rotate_on_eoi), .ocw2_level(ocw2_level),
    .int_out(int_out), .in_service_register(in_service_register), .priority_rotate(priority_rotate),
    .clear_interrupt_request(clear_interrupt_request), .data_out(data_out),
    .data_out_enable(data_out_enable)
  );

  always #5 clock = ~clock;

  // Reference model: step counts the INTA edges seen so far in the current two-pulse sequence.
  int         m_step;
  bit         m_prev, m_spur;
  int         m_lvl;
  logic [7:0] m_isr, m_clr, m_dout;
  logic [2:0] m_rot;
  logic       m_int, m_den;
  logic [4:0] m_base;

  function automatic int lowest_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_step = 0; m_prev = 1; m_spur = 0; m_lvl = 0;
      m_isr = 8'h00; m_clr = 8'h00; m_dout = 8'h00; m_rot = 3'd7;
      m_int = 0; m_den = 0; m_base = 5'b00000;
    end else begin
      bit fall, rise, rot_cmd;
      logic [7:0] n_isr;
      logic [2:0] n_rot;
      fall = !interrupt_ack_n && m_prev;
      rise = interrupt_ack_n && !m_prev;
      m_prev = interrupt_ack_n;
      n_isr = m_isr; n_rot = m_rot; rot_cmd = 0;
      if (eoi_specific) begin
        n_isr[ocw2_level] = 1'b0;
        if (rotate_on_eoi) begin n_rot = ocw2_level; rot_cmd = 1; end
      end else if (eoi_nonspecific) begin
        for (int k = 1; k <= 8; k++) begin
          int j;
          j = (int'(m_rot) + k) % 8;
          if (m_isr[j]) begin
            n_isr[j] = 1'b0;
            if (rotate_on_eoi) begin n_rot = 3'(j); rot_cmd = 1; end
            break;
          end
        end
      end else if (set_priority) begin
        n_rot = ocw2_level; rot_cmd = 1;
      end
      m_int = (m_step == 0) && !fall && (interrupt != 8'h00);
      m_clr = 8'h00;
      if (m_step == 0 && fall) begin
        if (interrupt != 8'h00) begin
          m_lvl = lowest_set(interrupt); m_spur = 0;
          n_isr[m_lvl] = 1'b1; m_clr = 8'h00; m_clr[m_lvl] = 1'b1;
        end else begin
          m_lvl = 7; m_spur = 1;
        end
        m_step = 1;
      end else if (m_step == 1 && rise) begin
        m_step = 2;
      end else if (m_step == 2 && fall) begin
        m_dout = {m_base, 3'(m_lvl)}; m_den = 1; m_step = 3;
      end else if (m_step == 3 && rise) begin
        m_den = 0; m_step = 0;
        if (auto_eoi && !m_spur) begin
          n_isr[m_lvl] = 1'b0;
          if (rotate_on_aeoi && !rot_cmd) n_rot = 3'(m_lvl);
        end
      end
      if (vector_base_load) m_base = vector_base;
      m_isr = n_isr; m_rot = n_rot;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("model int_out", {7'd0, int_out}, {7'd0, m_int});
      check("model isr", in_service_register, m_isr);
      check("model rotate", {5'd0, priority_rotate}, {5'd0, m_rot});
      check("model clear", clear_interrupt_request, m_clr);
      check("model den", {7'd0, data_out_enable}, {7'd0, m_den});
      check("model dout", data_out, m_dout);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("reset isr", in_service_register, 8'h00);
    check("reset rotate", {5'd0, priority_rotate}, 8'h07);
    check("reset den", {7'd0, data_out_enable}, 8'h00);

    // Basic ack, vector 0x43
    vector_base = 5'b01000; vector_base_load = 1; interrupt = 8'h08;
    cyc(1); vector_base_load = 0;
    cyc(1);
    check("basic int_out high", {7'd0, int_out}, 8'h01);
    interrupt_ack_n = 0; cyc(1);
    check("basic int_out low", {7'd0, int_out}, 8'h00);
    check("basic isr", in_service_register, 8'h08);
    check("basic clear", clear_interrupt_request, 8'h08);
    interrupt = 8'h00; cyc(1);
    check("basic clear pulse", clear_interrupt_request, 8'h00);
    interrupt_ack_n = 1; cyc(2);
    interrupt_ack_n = 0; cyc(1);
    check("basic den", {7'd0, data_out_enable}, 8'h01);
    check("basic vector", data_out, 8'h43);
    vector_base = 5'b11111; vector_base_load = 1; cyc(1); vector_base_load = 0;
    check("basic vector held", data_out, 8'h43);
    vector_base = 5'b01000; vector_base_load = 1;
    interrupt_ack_n = 1; cyc(1); vector_base_load = 0;
    check("basic den off", {7'd0, data_out_enable}, 8'h00);
    eoi_specific = 1; ocw2_level = 3'd3; cyc(1); eoi_specific = 0;
    check("specific eoi", in_service_register, 8'h00);

    // AEOI with rotation
    auto_eoi = 1; rotate_on_aeoi = 1; interrupt = 8'h20; cyc(1);
    interrupt_ack_n = 0; cyc(1);
    check("aeoi isr set", in_service_register, 8'h20);
    interrupt = 8'h00; cyc(1);
    interrupt_ack_n = 1; cyc(2);
    interrupt_ack_n = 0; cyc(2);
    interrupt_ack_n = 1; cyc(1);
    check("aeoi isr", in_service_register, 8'h00);
    check("aeoi rotate", {5'd0, priority_rotate}, 8'h05);
    auto_eoi = 0; rotate_on_aeoi = 0;

    // Build ISR=0x81, then non-specific EOI with wrap
    for (int p = 0; p < 2; p++) begin
      interrupt = (p == 0) ? 8'h80 : 8'h01; cyc(1);
      interrupt_ack_n = 0; cyc(1); interrupt = 8'h00; cyc(1);
      interrupt_ack_n = 1; cyc(2);
      interrupt_ack_n = 0; cyc(2);
      interrupt_ack_n = 1; cyc(2);
    end
    check("ns isr built", in_service_register, 8'h81);
    set_priority = 1; ocw2_level = 3'd0; cyc(1); set_priority = 0;
    check("set priority", {5'd0, priority_rotate}, 8'h00);
    eoi_nonspecific = 1; rotate_on_eoi = 1; cyc(1); eoi_nonspecific = 0; rotate_on_eoi = 0;
    check("ns wrap isr", in_service_register, 8'h01);
    check("ns wrap rotate", {5'd0, priority_rotate}, 8'h07);
    eoi_nonspecific = 1; cyc(1); eoi_nonspecific = 0;
    check("ns second isr", in_service_register, 8'h00);
    eoi_nonspecific = 1; rotate_on_eoi = 1; cyc(1); eoi_nonspecific = 0; rotate_on_eoi = 0;
    check("ns empty rotate", {5'd0, priority_rotate}, 8'h07);

    // Spurious
    interrupt = 8'h04; cyc(2);
    check("spur int_out", {7'd0, int_out}, 8'h01);
    interrupt = 8'h00; cyc(1);
    interrupt_ack_n = 0; cyc(1);
    check("spur clear", clear_interrupt_request, 8'h00);
    check("spur isr", in_service_register, 8'h00);
    cyc(1); interrupt_ack_n = 1; cyc(2);
    interrupt_ack_n = 0; cyc(1);
    check("spur vector", data_out, 8'h47);
    cyc(1); interrupt_ack_n = 1; cyc(2);

    // Collisions: EOI and INTA#1 on the same cycle
    interrupt = 8'h04; cyc(1);
    interrupt_ack_n = 0; cyc(1); interrupt = 8'h00; cyc(1);
    interrupt_ack_n = 1; cyc(2); interrupt_ack_n = 0; cyc(2); interrupt_ack_n = 1; cyc(2);
    interrupt = 8'h02; cyc(1);
    eoi_specific = 1; ocw2_level = 3'd2; interrupt_ack_n = 0; cyc(1);
    eoi_specific = 0; interrupt = 8'h00;
    check("collision isr", in_service_register, 8'h02);
    cyc(1); interrupt_ack_n = 1; cyc(2); interrupt_ack_n = 0; cyc(2); interrupt_ack_n = 1; cyc(2);
    interrupt = 8'h06; cyc(1);
    eoi_specific = 1; ocw2_level = 3'd1; interrupt_ack_n = 0; cyc(1);
    eoi_specific = 0; interrupt = 8'h00;
    check("collision same bit", in_service_register, 8'h02);
    check("collision clear", clear_interrupt_request, 8'h02);
    cyc(1); interrupt_ack_n = 1; cyc(2); interrupt_ack_n = 0; cyc(2); interrupt_ack_n = 1; cyc(2);

    // Reset while in WAIT2
    interrupt = 8'h10; cyc(1);
    interrupt_ack_n = 0; cyc(1); interrupt = 8'h00; cyc(1);
    interrupt_ack_n = 1; cyc(2);
    #2 reset = 1; #1;
    check("async isr", in_service_register, 8'h00);
    check("async rotate", {5'd0, priority_rotate}, 8'h07);
    check("async int_out", {7'd0, int_out}, 8'h00);
    check("async dout", data_out, 8'h00);
    check("async den", {7'd0, data_out_enable}, 8'h00);
    cyc(2); reset = 0;
    interrupt = 8'h01; cyc(1);
    interrupt_ack_n = 0; cyc(1);
    check("post reset isr", in_service_register, 8'h01);
    check("post reset clear", clear_interrupt_request, 8'h01);
    interrupt = 8'h00; cyc(1);
    interrupt_ack_n = 1; cyc(2); interrupt_ack_n = 0; cyc(1);
    check("post reset vector", data_out, 8'h00);
    cyc(1); interrupt_ack_n = 1; cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
